note_sequencer: RTL and testbench

Sequences a queue of note commands onto the clock divider that generates the audio tone. Each command's note code is translated into the divider's half-period count, and the note is held for a beat-timed duration. The divider is held in reset during rests, idle time, pause and inter-note gaps. The block sits between the player control logic, which pushes commands, and the divider, whose count and reset inputs it drives.

---
 rtl/note_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note command sequencer: queues {note, beats} commands and drives the tone divider's
// half-period count and reset, holding each note for a beat-timed duration plus a silent gap.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 250_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_note,
  input  logic [3:0]  cmd_beats,
  input  logic        pause,
  output logic [31:0] div_clk_count,
  output logic        div_reset,
  output logic        busy,
  output logic [3:0]  note_active
);

  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [31:0]   BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;

  // Half-period counts for a 50 MHz clock; every non-note code is silent.
  function automatic logic [31:0] note_count(input logic [3:0] note);
    case (note)
      4'd1:    note_count = 32'd47800;
      4'd2:    note_count = 32'd42588;
      4'd3:    note_count = 32'd37935;
      4'd4:    note_count = 32'd35816;
      4'd5:    note_count = 32'd31928;
      4'd6:    note_count = 32'd28408;
      4'd7:    note_count = 32'd25328;
      4'd8:    note_count = 32'd23900;
      default: note_count = 32'd0;
    endcase
  endfunction

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_e        r_state;
  logic [3:0]    r_note;
  logic [3:0]    r_beats;
  logic [3:0]    r_beats_left;
  logic [31:0]   r_beat_cnt;
  logic [31:0]   r_gap_cnt;
  logic [31:0]   r_div_clk_count;
  logic          r_div_reset;
  logic          r_busy;
  logic [3:0]    r_note_active;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_head;
  logic          w_sound;
  logic          w_queue_left;

  assign cmd_ready     = (r_count != FULL_CNT);
  assign w_push        = cmd_valid & cmd_ready;
  assign w_pop         = (r_state == StIdle) & (r_count != '0) & ~pause;
  assign w_count_next  = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  assign w_head        = r_mem[r_rd_ptr];
  assign w_sound       = (r_note != 4'd0) && (r_note <= 4'd8);
  // Busy value to register on any transition into IDLE.
  assign w_queue_left  = (w_count_next != '0);

  assign div_clk_count = r_div_clk_count;
  assign div_reset     = r_div_reset;
  assign busy          = r_busy;
  assign note_active   = r_note_active;

  always_ff @(posedge inclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_note, cmd_beats};
    end
  end

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      r_state         <= StIdle;
      r_note          <= 4'd0;
      r_beats         <= 4'd0;
      r_beats_left    <= 4'd0;
      r_beat_cnt      <= 32'd0;
      r_gap_cnt       <= 32'd0;
      r_div_clk_count <= 32'd0;
      r_div_reset     <= 1'b1;
      r_busy          <= 1'b0;
      r_note_active   <= 4'd0;
    end else begin
      r_busy <= 1'b1;
      unique case (r_state)
        StIdle: begin
          r_div_reset   <= 1'b1;
          r_note_active <= 4'd0;
          if (w_pop) begin
            r_note  <= w_head[7:4];
            r_beats <= w_head[3:0];
            r_state <= StLoad;
          end else begin
            r_busy <= w_queue_left;
          end
        end

        // LOAD ignores pause so a popped command is never left half-loaded.
        StLoad: begin
          r_div_clk_count <= note_count(r_note);
          if (r_beats == 4'd0) begin
            r_state <= StIdle;
            r_busy  <= w_queue_left;
          end else begin
            r_state       <= StPlay;
            r_beat_cnt    <= 32'd0;
            r_beats_left  <= r_beats;
            r_div_reset   <= ~w_sound;
            r_note_active <= w_sound ? r_note : 4'd0;
          end
        end

        StPlay: begin
          if (pause) begin
            r_div_reset   <= 1'b1;
            r_note_active <= 4'd0;
          end else if (r_beat_cnt == BEAT_LAST && r_beats_left == 4'd1) begin
            r_beat_cnt    <= 32'd0;
            r_div_reset   <= 1'b1;
            r_note_active <= 4'd0;
            if (GAP_CYCLES == 0) begin
              r_state <= StIdle;
              r_busy  <= w_queue_left;
            end else begin
              r_state   <= StGap;
              r_gap_cnt <= 32'd0;
            end
          end else begin
            if (r_beat_cnt == BEAT_LAST) begin
              r_beat_cnt   <= 32'd0;
              r_beats_left <= r_beats_left - 4'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            r_div_reset   <= ~w_sound;
            r_note_active <= w_sound ? r_note : 4'd0;
          end
        end

        StGap: begin
          r_div_reset   <= 1'b1;
          r_note_active <= 4'd0;
          if (!pause) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= StIdle;
              r_busy  <= w_queue_left;
            end else begin
              r_gap_cnt <= r_gap_cnt + 32'd1;
            end
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues expected sound segments and busy
// episodes; a negedge monitor measures what the DUT actually produced and compares.
module tb_note_sequencer;

  logic        inclk = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_note;
  logic [3:0]  cmd_beats;
  logic        pause;
  logic [31:0] div_clk_count;
  logic        div_reset;
  logic        busy;
  logic [3:0]  note_active;

  note_sequencer #(
    .BEAT_CYCLES (10),
    .GAP_CYCLES  (3),
    .FIFO_DEPTH  (4)
  ) dut (
    .inclk         (inclk),
    .Reset         (Reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_note      (cmd_note),
    .cmd_beats     (cmd_beats),
    .pause         (pause),
    .div_clk_count (div_clk_count),
    .div_reset     (div_reset),
    .busy          (busy),
    .note_active   (note_active)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    int note;
    int count;
    int len;
    int gap;   // silent samples since previous segment in the same episode, -1 = first
  } seg_t;

  seg_t exp_seg[$];
  int   exp_busy[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_s(input int note, input int count, input int len, input int gap);
    seg_t s;
    s.note = note; s.count = count; s.len = len; s.gap = gap;
    exp_seg.push_back(s);
  endtask

  // Monitor: sound segments are runs of div_reset == 0, episodes are runs of busy == 1.
  int cyc = 0, seg_len = 0, seg_note = 0, seg_count = 0, seg_gap = -1;
  int last_end = 0, busy_len = 0;
  bit have_last = 1'b0, prev_dr = 1'b1, prev_busy = 1'b0;

  always @(negedge inclk) begin
    seg_t s;
    cyc++;
    if (!div_reset) begin
      if (prev_dr) begin
        seg_len   = 1;
        seg_note  = int'(note_active);
        seg_count = int'(div_clk_count);
        seg_gap   = have_last ? cyc - last_end : -1;
      end else begin
        seg_len++;
      end
    end else begin
      check("silent_note_active", int'(note_active), 0);
      if (!prev_dr) begin
        if (exp_seg.size() == 0) begin
          check("unexpected_segment_note", seg_note, -1);
        end else begin
          s = exp_seg.pop_front();
          check("seg_note", seg_note, s.note);
          check("seg_count", seg_count, s.count);
          check("seg_len", seg_len, s.len);
          if (s.gap >= 0) check("seg_gap", seg_gap, s.gap);
        end
        last_end  = cyc;
        have_last = 1'b1;
      end
    end
    if (busy) begin
      busy_len = prev_busy ? busy_len + 1 : 1;
    end else if (prev_busy) begin
      if (exp_busy.size() == 0) check("unexpected_busy_len", busy_len, -1);
      else check("busy_len", busy_len, exp_busy.pop_front());
      have_last = 1'b0;
    end
    prev_dr   = div_reset;
    prev_busy = busy;
  end

  task automatic push(input int note, input int beats);
    int w = 0;
    while (!cmd_ready && w < 200) begin
      @(posedge inclk); #1;
      w++;
    end
    check("push_ready", int'(cmd_ready), 1);
    cmd_note  = 4'(note);
    cmd_beats = 4'(beats);
    cmd_valid = 1'b1;
    @(posedge inclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while (busy && i < bound) begin
      @(posedge inclk); #1;
      i++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (3) @(posedge inclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0; cmd_note = 4'd0; cmd_beats = 4'd0; pause = 1'b0;
    #2;
    check("rst_div_clk_count", int'(div_clk_count), 0);
    check("rst_div_reset", int'(div_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_note_active", int'(note_active), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    #20 Reset = 1'b0;
    @(posedge inclk); #1;

    // 1: single note 6, two beats.
    exp_s(6, 28408, 20, -1);
    exp_busy.push_back(25);
    push(6, 2);
    @(posedge inclk); #1;
    check("t1_edge1_div_reset", int'(div_reset), 1);
    @(posedge inclk); #1;
    check("t1_edge2_div_reset", int'(div_reset), 0);
    check("t1_edge2_note", int'(note_active), 6);
    check("t1_edge2_count", int'(div_clk_count), 28408);
    wait_idle(100);

    // 2: fill the queue while pops are blocked, then play all five in order.
    exp_s(1, 47800, 10, -1);
    exp_s(2, 42588, 20, 5);
    exp_s(3, 37935, 10, 5);
    exp_s(4, 35816, 10, 5);
    exp_s(5, 31928, 10, 5);
    exp_busy.push_back(88);
    pause = 1'b1;
    push(1, 1);
    push(2, 2);
    push(3, 1);
    push(4, 1);
    check("t2_full_ready", int'(cmd_ready), 0);
    pause = 1'b0;
    push(5, 1);
    wait_idle(300);

    // 3: rests never sound; combined busy covers PLAY of 30 and 10 cycles.
    exp_busy.push_back(50);
    push(0, 3);
    push(12, 1);
    wait_idle(200);
    check("t3_rest_count", int'(div_clk_count), 0);

    // 4: zero-beat command is discarded, next note follows immediately.
    exp_s(1, 47800, 10, -1);
    exp_busy.push_back(17);
    push(3, 0);
    push(1, 1);
    @(posedge inclk); #1;
    check("t4_s2_div_reset", int'(div_reset), 1);
    @(posedge inclk); #1;
    check("t4_s3_div_reset", int'(div_reset), 1);
    @(posedge inclk); #1;
    check("t4_s4_div_reset", int'(div_reset), 0);
    check("t4_s4_note", int'(note_active), 1);
    wait_idle(100);

    // 5: seven-cycle pause in the middle of a one-beat note 8.
    exp_s(8, 23900, 5, -1);
    exp_s(8, 23900, 5, 7);
    exp_busy.push_back(22);
    push(8, 1);
    repeat (6) @(posedge inclk);
    #1 pause = 1'b1;
    repeat (3) @(posedge inclk);
    #1;
    check("t5_paused_div_reset", int'(div_reset), 1);
    repeat (4) @(posedge inclk);
    #1 pause = 1'b0;
    wait_idle(100);

    // 6: asynchronous reset mid-PLAY with two commands still queued.
    exp_s(7, 25328, 10, -1);
    exp_busy.push_back(12);
    push(7, 3);
    push(2, 1);
    push(4, 1);
    repeat (10) @(posedge inclk);
    #3 Reset = 1'b1;
    #1;
    check("t6_div_reset", int'(div_reset), 1);
    check("t6_note", int'(note_active), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_count", int'(div_clk_count), 0);
    check("t6_ready", int'(cmd_ready), 1);
    #10 Reset = 1'b0;
    repeat (40) @(posedge inclk);
    #1;
    check("t6_after_busy", int'(busy), 0);
    check("t6_after_ready", int'(cmd_ready), 1);
    check("t6_after_div_reset", int'(div_reset), 1);

    repeat (5) @(posedge inclk);
    check("pending_segments", exp_seg.size(), 0);
    check("pending_busy", exp_busy.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
